// File: rtl/halton3_pkg.sv
// Shared constants, divisor helper and FSM encoding for the base-3 Halton
// radical-inverse block.
package halton3_pkg;
  localparam int BASE      = 3;
  localparam int LOGBASE   = 2;  // bits per packed base-3 digit
  localparam int NDIG_DEF  = 5;
  localparam int WIDTH_DEF = 8;

  // 3^n, used as the divisor of the fixed-point conversion
  function automatic int pow3(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * BASE;
    return p;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/halton3_rev_sum.sv
// Combinational digit-reversal sum: R = sum d_i * 3^(NDIG-1-i).
// Illegal digit 2'b11 is clamped to 2 and raises err.
//   digits : packed base-3 digits, digit i at [2i+1:2i]
//   r      : reversed-weight integer, always < 3^NDIG
//   err    : at least one digit was 2'b11
module halton3_rev_sum
  import halton3_pkg::*;
#(
  parameter int NDIG = NDIG_DEF,
  parameter int RW   = 9
) (
  input  logic [LOGBASE*NDIG-1:0] digits,
  output logic [RW-1:0]           r,
  output logic                    err
);

  logic [LOGBASE-1:0] d;

  // Horner from d0 down: d0 ends up with the largest weight 3^(NDIG-1)
  always_comb begin
    r   = '0;
    err = 1'b0;
    d   = '0;
    for (int i = 0; i < NDIG; i++) begin
      d = digits[LOGBASE*i +: LOGBASE];
      if (d == 2'b11) begin
        d   = 2'b10;
        err = 1'b1;
      end
      r = r * RW'(BASE) + RW'(d);
    end
  end

endmodule

// File: rtl/halton3_radical_inv.sv
// Base-3 radical inverse to binary fraction: out = floor(R * 2^WIDTH / 3^NDIG)
// by a WIDTH-cycle restoring division, MSB first.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : digit-vector handshake (ready only in IDLE)
//   digits              : packed base-3 digits
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out, err            : fraction and illegal-digit flag, held through DONE
module halton3_radical_inv
  import halton3_pkg::*;
#(
  parameter int NDIG  = NDIG_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LOGBASE*NDIG-1:0] digits,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    err
);

  localparam int DIV = pow3(NDIG);
  localparam int RW  = $clog2(DIV) + 1;  // room for 2*rem before subtract
  localparam int CW  = $clog2(WIDTH + 1);

  state_t         state, nxt;
  logic [RW-1:0]  rem, rem2, r_sum;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]  cnt;
  logic           err_q, r_err;
  logic           accept, release_res, take, last;

  halton3_rev_sum #(.NDIG(NDIG), .RW(RW)) u_rev_sum (
    .digits (digits),
    .r      (r_sum),
    .err    (r_err)
  );

  assign accept      = in_valid & in_ready;
  assign release_res = out_valid & out_ready;
  // rem < DIV so its top bit is zero; shifting it out loses nothing
  assign rem2        = {rem[RW-2:0], 1'b0};
  assign take        = (rem2 >= RW'(DIV));
  assign last        = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept)      nxt = BUSY;
      BUSY:    if (last)        nxt = DONE;
      DONE:    if (release_res) nxt = IDLE;
      default:                  nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      rem   <= r_sum;
      quo   <= '0;
      cnt   <= '0;
      err_q <= r_err;
    end else if (state == BUSY) begin
      rem <= take ? (rem2 - RW'(DIV)) : rem2;
      quo <= {quo[WIDTH-2:0], take};
      cnt <= cnt + CW'(1);
    end
  end

  assign out = quo;
  assign err = err_q;

endmodule

// File: tb/tb_halton3_radical_inv.sv
// Self-checking bench for halton3_radical_inv (NDIG=5, WIDTH=8).
module tb_halton3_radical_inv;
  localparam int NDIG  = 5;
  localparam int WIDTH = 8;
  localparam int DIV   = 243;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2*NDIG-1:0] digits;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             err;

  int n_vec = 0;
  int n_err = 0;

  halton3_radical_inv #(.NDIG(NDIG), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .digits    (digits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: radical inverse from the digit values with plain arithmetic
  function automatic int model_r(input logic [2*NDIG-1:0] dv);
    int r, w, d;
    r = 0;
    w = DIV / 3;
    for (int i = 0; i < NDIG; i++) begin
      d = int'(dv[2*i +: 2]);
      if (d == 3) d = 2;
      r = r + d * w;
      w = w / 3;
    end
    return r;
  endfunction

  function automatic int model_out(input logic [2*NDIG-1:0] dv);
    return (model_r(dv) * (1 << WIDTH)) / DIV;
  endfunction

  function automatic int model_err(input logic [2*NDIG-1:0] dv);
    int e;
    e = 0;
    for (int i = 0; i < NDIG; i++) if (dv[2*i +: 2] == 2'b11) e = 1;
    return e;
  endfunction

  // counter value n -> packed digits, digit 0 least significant counter
  function automatic logic [2*NDIG-1:0] vec_of(input int n);
    logic [2*NDIG-1:0] v;
    int m;
    v = '0;
    m = n;
    for (int i = 0; i < NDIG; i++) begin
      v[2*i +: 2] = 2'(m % 3);
      m = m / 3;
    end
    return v;
  endfunction

  // One transaction; inputs change #1 after posedge, outputs sampled there too.
  task automatic run_txn(input logic [2*NDIG-1:0] dv, input int eo, input int ee,
                         input int stall, input string nm);
    int t;
    bit bad;
    logic [WIDTH-1:0] o_snap;
    logic e_snap;
    digits    = dv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk({nm, "_in_ready"}, int'(in_ready), 1);
    @(posedge clk); #1;               // accept edge
    in_valid = 1'b0;
    bad = 1'b0;
    for (int k = 1; k < WIDTH; k++) begin
      digits = 10'($urandom);         // must not disturb the running result
      @(posedge clk); #1;
      if (out_valid || in_ready) bad = 1'b1;
    end
    chk({nm, "_busy_quiet"}, int'(bad), 0);
    @(posedge clk); #1;               // 9th edge counting the accept edge
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_out"}, int'(out), eo);
    chk({nm, "_err"}, int'(err), ee);
    if (stall > 0) begin
      o_snap = out;
      e_snap = err;
      bad = 1'b0;
      repeat (stall) begin
        digits   = 10'($urandom);
        in_valid = 1'($urandom);
        @(posedge clk); #1;
        if (!out_valid || in_ready || out !== o_snap || err !== e_snap) bad = 1'b1;
      end
      in_valid = 1'b0;
      chk({nm, "_hold"}, int'(bad), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_idle_ready"}, int'(in_ready), 1);
    chk({nm, "_idle_valid"}, int'(out_valid), 0);
  endtask

  typedef struct {
    logic [2*NDIG-1:0] dig;
    int                exp_out;
    int                exp_err;
    string             nm;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{10'b00_00_00_00_00,   0, 0, "zero"};
    tbl[1] = '{10'b00_00_00_00_01,  85, 0, "d0_1"};
    tbl[2] = '{10'b00_00_00_00_10, 170, 0, "d0_2"};
    tbl[3] = '{10'b00_00_00_01_00,  28, 0, "d1_1"};
    tbl[4] = '{10'b10_10_10_10_10, 254, 0, "all_2"};
    tbl[5] = '{10'b00_00_00_00_11, 170, 1, "d0_illegal"};
    tbl[6] = '{10'b00_00_00_00_01,  85, 0, "after_illegal"};
    tbl[7] = '{10'b11_11_11_11_11, 254, 1, "all_illegal"};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    digits    = '0;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 1);

    // directed table
    foreach (tbl[i]) run_txn(tbl[i].dig, tbl[i].exp_out, tbl[i].exp_err, 0, tbl[i].nm);

    // back-pressure: 20 cycles with out_ready low
    run_txn(10'b00_00_00_00_10, 170, 0, 20, "backpressure");

    // reset at BUSY cycle 4 discards the transaction
    digits   = 10'b10_10_10_10_10;
    in_valid = 1'b1;
    @(posedge clk); #1;               // accept
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midbusy_rst_valid", int'(out_valid), 0);
    chk("midbusy_rst_out", int'(out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midbusy_rel_ready", int'(in_ready), 1);
    begin
      bit bad;
      bad = 1'b0;
      repeat (15) begin
        @(posedge clk); #1;
        if (out_valid || !in_ready) bad = 1'b1;
      end
      chk("midbusy_no_stale", int'(bad), 0);
    end

    // random vectors against the model
    for (int i = 0; i < 30; i++) begin
      logic [2*NDIG-1:0] dv;
      dv = 10'($urandom);
      run_txn(dv, model_out(dv), model_err(dv), $urandom_range(0, 3), "rand");
    end

    // full counter sweep 0..242 with everything streaming
    begin
      logic [2*NDIG-1:0] qdig[$];
      logic [2*NDIG-1:0] dd;
      int n_acc, n_res, cyc, first_acc, last_acc;
      bit acc, res;
      n_acc = 0; n_res = 0; cyc = 0; first_acc = 0; last_acc = 0;
      out_ready = 1'b1;
      digits    = vec_of(0);
      in_valid  = 1'b1;
      while (n_res < DIV && cyc < 3000) begin
        acc = in_valid && in_ready;
        res = out_valid && out_ready;
        if (res) begin
          if (qdig.size() == 0) chk("sweep_dup", 1, 0);
          else begin
            dd = qdig.pop_front();
            chk("sweep_out", int'(out), model_out(dd));
          end
          n_res++;
        end
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          qdig.push_back(digits);
          if (n_acc == 0) first_acc = cyc;
          last_acc = cyc;
          n_acc++;
          if (n_acc < DIV) digits = vec_of(n_acc);
          else in_valid = 1'b0;
        end
      end
      chk("sweep_results", n_res, DIV);
      chk("sweep_accepts", n_acc, DIV);
      chk("sweep_leftover", qdig.size(), 0);
      chk("sweep_period", last_acc - first_acc, (DIV - 1) * (WIDTH + 2));
      out_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/halton3_radical_inv.md
HALTON3_RADICAL_INV -- requirements
Module: halton3_radical_inv

Interface
REQ-001 Parameter NDIG, default 5: number of base-3 digits consumed (3^NDIG SHALL fit in WIDTH bits).
REQ-002 Parameter WIDTH, default 8: output fraction width in bits.
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  digit vector present.
REQ-006 in_ready  output  1  block able to accept a digit vector.
REQ-007 digits  input  2*NDIG  packed base-3 digits from the counter chain; digit i at bits [2i+1:2i], i=0 least significant counter.
REQ-008 out_valid  output  1  result present on out.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out  output  WIDTH  binary radical inverse, floor(R*2^WIDTH / 3^NDIG).
REQ-011 err  output  1  set with a result whose input held an illegal digit (2'b11).

Function
REQ-012 Radical inverse: R = sum over i of d_i * 3^(NDIG-1-i); d0 has weight 1/3 in the fraction.
REQ-013 Illegal digit 2'b11 SHALL be treated as 2 and SHALL set err for that transaction only.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid&in_ready edge, capture R into remainder register, clear quotient and bit counter, go BUSY.
REQ-016 BUSY: per cycle restoring division step, rem2 = 2*rem; if rem2 >= 3^NDIG then quotient bit 1, rem = rem2-3^NDIG, else bit 0, rem = rem2; bits shift in MSB first.
REQ-017 BUSY lasts exactly WIDTH cycles, then go DONE; out_valid rises WIDTH+1 rising edges after the accept edge.
REQ-018 DONE: out and err held stable until out_valid&out_ready edge, then go IDLE; no input accepted in DONE or BUSY.
REQ-019 Back-pressure: out_ready low holds DONE indefinitely with no change of out.
REQ-020 Digit changes on the input while BUSY/DONE SHALL have no effect on the current result.
REQ-021 Remainder register width ceil(log2(3^NDIG))+1; quotient never overflows since R < 3^NDIG.
REQ-022 Throughput: one result per WIDTH+2 cycles with out_ready held high.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, out=0, err=0, out_valid=0, remainder and counter 0; in_ready=1 after release.
REQ-024 Reset asserted mid-BUSY or mid-DONE SHALL discard the transaction; no out_valid pulse follows release.

Structure
REQ-025 Package halton3_pkg SHALL hold BASE=3, LOGBASE=2, default NDIG/WIDTH, the 3^NDIG divisor function and the FSM state enum.
REQ-026 Combinational sub-module halton3_rev_sum SHALL map digits to R with illegal-digit clamp and error flag; halton3_radical_inv instantiates it once.

Verification
REQ-027 digits all 0, accept -> after 9 edges out_valid=1, out=0, err=0.
REQ-028 d0=1 others 0 (R=81) -> out=85; d0=2 (R=162) -> out=170; d1=1 (R=27) -> out=28.
REQ-029 all digits 2 (R=242) -> out=254; d0=2'b11 others 0 -> out=170, err=1; next legal input -> err=0.
REQ-030 out_ready low 20 cycles after out_valid -> out, out_valid stable, in_ready=0; out_ready high -> IDLE next edge, in_ready=1.
REQ-031 rst_n low at BUSY cycle 4 -> out_valid=0, in_ready=1 after release, no stale result emitted.
REQ-032 Drive a full ModCnt-style counter sequence 0..242 with out_ready=1 -> 243 results matching floor(R*256/243), no missed or duplicated transactions.
